// File: rtl/depth_pkg.sv
// Shared FSM state encoding and depth constants for the stereo depth scheduler.
package depth_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DIVIDE,
        S_OUTPUT
    } state_t;

    localparam int unsigned DEFAULT_SCALE = 495;
    localparam logic [7:0]  DEPTH_SAT     = 8'hFF;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, W bits in total.
// The first bit is resolved on the start edge, so done is high W cycles after start.
module serial_divider #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     rem_q;
    logic [W-1:0]     rem_d;
    logic [W-1:0]     den_q;
    logic [W-1:0]     den_d;
    logic [W-1:0]     quo_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_d;
    logic             done_d;
    logic [W-1:0]     src_rem;
    logic [W-1:0]     src_quo;
    logic [W:0]       shifted;
    logic [W:0]       trial;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quotient;
        den_d   = start ? divisor : den_q;
        shifted = {src_rem, src_quo[W-1]};
        trial   = shifted - {1'b0, den_d};
        rem_d   = rem_q;
        quo_d   = quotient;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        if (start || busy) begin
            if (trial[W]) begin
                rem_d = shifted[W-1:0];
                quo_d = {src_quo[W-2:0], 1'b0};
            end else begin
                rem_d = trial[W-1:0];
                quo_d = {src_quo[W-2:0], 1'b1};
            end
            cnt_d  = start ? CNT_W'(W - 1) : cnt_q - CNT_W'(1);
            busy_d = (cnt_d != '0);
            done_d = (cnt_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            den_q    <= '0;
            quotient <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            den_q    <= den_d;
            quotient <= quo_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: rtl/depth_scheduler.sv
// Round-robin scheduler that turns stereo x-coordinate pairs into saturated depth in inches.
// NUM_CH must be at least 2 so that ch_out has a non-zero width.
module depth_scheduler
    import depth_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DISP_W = 12,
    parameter int unsigned SCALE  = DEFAULT_SCALE
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_CH-1:0]          req_valid_in,
    output logic [NUM_CH-1:0]          req_ready_out,
    input  logic [NUM_CH*DISP_W-1:0]   x_1_in,
    input  logic [NUM_CH*DISP_W-1:0]   x_2_in,
    output logic                       depth_valid_out,
    input  logic                       depth_ready_in,
    output logic [7:0]                 depth_out,
    output logic [$clog2(NUM_CH)-1:0]  ch_out,
    output logic                       err_out
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   ptr_d;
    logic [DISP_W-1:0] x1_q;
    logic [DISP_W-1:0] x1_d;
    logic [DISP_W-1:0] x2_q;
    logic [DISP_W-1:0] x2_d;
    logic [CH_W-1:0]   ch_d;
    logic [7:0]        depth_d;
    logic              err_d;
    logic              valid_d;

    logic [NUM_CH-1:0] grant_c;
    logic [CH_W-1:0]   win_c;
    logic [CH_W-1:0]   idx_c;
    logic              found_c;
    logic [DISP_W-1:0] x1_sel_c;
    logic [DISP_W-1:0] x2_sel_c;
    logic [DISP_W:0]   disp_c;
    logic              nonpos_c;
    logic [7:0]        sat_c;

    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DISP_W-1:0] quot;

    // Round-robin search starting at the grant pointer.
    always_comb begin
        grant_c = '0;
        win_c   = '0;
        idx_c   = '0;
        found_c = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_c = CH_W'((int'(ptr_q) + i) % NUM_CH);
            if (!found_c && req_valid_in[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
        if (found_c) grant_c[win_c] = 1'b1;
    end

    // Ready is offered only in IDLE and is forced low while reset is held.
    always_comb begin
        req_ready_out = '0;
        if (state_q == S_IDLE && rst_n_in) req_ready_out = grant_c;
    end

    always_comb begin
        x1_sel_c = '0;
        x2_sel_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_c == CH_W'(i)) begin
                x1_sel_c = x_1_in[i*DISP_W +: DISP_W];
                x2_sel_c = x_2_in[i*DISP_W +: DISP_W];
            end
        end
    end

    // Two's-complement disparity; MSB set means x_1 < x_2.
    assign disp_c   = {1'b0, x1_q} - {1'b0, x2_q};
    assign nonpos_c = disp_c[DISP_W] || (disp_c == '0);
    assign sat_c    = (32'(quot) > 32'd255) ? 8'd255 : 8'(quot);

    serial_divider #(
        .W (DISP_W)
    ) u_div (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .start    (div_start),
        .dividend (DISP_W'(SCALE)),
        .divisor  (disp_c[DISP_W-1:0]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quot)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        ch_d      = ch_out;
        depth_d   = depth_out;
        err_d     = err_out;
        valid_d   = depth_valid_out;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    ptr_d   = CH_W'((int'(win_c) + 1) % NUM_CH);
                    x1_d    = x1_sel_c;
                    x2_d    = x2_sel_c;
                    ch_d    = win_c;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (nonpos_c) begin
                    depth_d = DEPTH_SAT;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end else begin
                    div_start = 1'b1;
                    state_d   = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (div_done && !div_busy) begin
                    depth_d = sat_c;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (depth_ready_in) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            x1_q            <= '0;
            x2_q            <= '0;
            ch_out          <= '0;
            depth_out       <= '0;
            err_out         <= 1'b0;
            depth_valid_out <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            x1_q            <= x1_d;
            x2_q            <= x2_d;
            ch_out          <= ch_d;
            depth_out       <= depth_d;
            err_out         <= err_d;
            depth_valid_out <= valid_d;
        end
    end

endmodule

// File: tb/tb_depth_scheduler.sv
// Self-checking bench for depth_scheduler: directed corners plus random requests
// compared against an arithmetic depth/latency model and a round-robin order model.
module tb_depth_scheduler;

    localparam int NUM_CH  = 2;
    localparam int DISP_W  = 12;
    localparam int SCALE   = 495;
    localparam int LAT_OK  = DISP_W + 2;
    localparam int LAT_ERR = 2;
    localparam int TMO     = 60;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*DISP_W-1:0] x1;
    logic [NUM_CH*DISP_W-1:0] x2;
    logic                     depth_valid;
    logic                     depth_ready;
    logic [7:0]               depth;
    logic [0:0]               ch;
    logic                     err;

    int n_checks = 0;
    int n_fail   = 0;

    depth_scheduler #(
        .NUM_CH (NUM_CH),
        .DISP_W (DISP_W),
        .SCALE  (SCALE)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .req_valid_in    (req_valid),
        .req_ready_out   (req_ready),
        .x_1_in          (x1),
        .x_2_in          (x2),
        .depth_valid_out (depth_valid),
        .depth_ready_in  (depth_ready),
        .depth_out       (depth),
        .ch_out          (ch),
        .err_out         (err)
    );

    always #5 clk = ~clk;

    // Reference: depth = floor(SCALE / (x1 - x2)) clipped to 255, error when disparity <= 0.
    function automatic void model(input int a, input int b, output logic [7:0] d,
                                  output logic e, output int lat);
        int disp;
        int q;
        disp = a - b;
        if (disp <= 0) begin
            d = 8'hFF; e = 1'b1; lat = LAT_ERR;
        end else begin
            q = SCALE / disp;
            d = (q > 255) ? 8'd255 : 8'(q);
            e = 1'b0; lat = LAT_OK;
        end
    endfunction

    task automatic set_x(input int c, input int a, input int b);
        x1[c*DISP_W +: DISP_W] = DISP_W'(a);
        x2[c*DISP_W +: DISP_W] = DISP_W'(b);
    endtask

    task automatic scramble_idle_x();
        for (int c = 0; c < NUM_CH; c++)
            if (!req_valid[c]) set_x(c, $urandom_range(0, 4095), $urandom_range(0, 4095));
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the accept.
    task automatic send(input int c, input int a, input int b, output bit ok);
        ok = 1'b0;
        set_x(c, a, b);
        req_valid[c] = 1'b1;
        for (int i = 0; i < TMO && !ok; i++) begin
            #1;
            if (req_ready[c]) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid[c] = 1'b0;
        scramble_idle_x();
    endtask

    task automatic wait_result(output int lat, output bit ok);
        int n;
        n = 1;
        while (!depth_valid && n < TMO) begin
            @(negedge clk);
            scramble_idle_x();
            n++;
        end
        ok  = depth_valid;
        lat = n;
    endtask

    task automatic release_result();
        depth_ready = 1'b1;
        @(negedge clk);
        depth_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; depth_ready = 1'b0;
        set_x(0, 600, 595); set_x(1, 700, 690);
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready_clk got=%b exp=00", req_ready); end
        n_checks++; if (depth_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", depth_valid); end
        n_checks++; if ({depth, ch, err} !== 10'd0) begin n_fail++; $display("FAIL reset_outputs got depth=%0d ch=%0d err=%b exp=0/0/0", depth, ch, err); end
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit ok; int lat;
        send(0, 600, 595, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_accept got=timeout exp=accept"); end
        wait_result(lat, ok);
        n_checks++; if (!ok || lat != LAT_OK) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT_OK); end
        n_checks++; if (depth !== 8'd99 || err !== 1'b0 || ch !== 1'b0) begin
            n_fail++; $display("FAIL single_result got depth=%0d err=%b ch=%0d exp=99/0/0", depth, err, ch); end
        release_result();
        n_checks++; if (depth_valid !== 1'b0) begin n_fail++; $display("FAIL single_handshake got=%b exp=0", depth_valid); end
    endtask

    task automatic test_boundary();
        int av[5] = '{600, 990, 700, 300, 100};
        int bv[5] = '{599, 495, 100, 300, 200};
        bit ok; int lat; int elat; logic [7:0] ed; logic ee;
        for (int i = 0; i < 5; i++) begin
            model(av[i], bv[i], ed, ee, elat);
            send(i % 2, av[i], bv[i], ok);
            wait_result(lat, ok);
            n_checks++; if (!ok || lat != elat) begin n_fail++; $display("FAIL boundary%0d_latency got=%0d exp=%0d", i, lat, elat); end
            n_checks++; if (depth !== ed || err !== ee || ch !== 1'(i % 2)) begin
                n_fail++; $display("FAIL boundary%0d_result got depth=%0d err=%b ch=%0d exp=%0d/%b/%0d", i, depth, err, ch, ed, ee, i % 2); end
            release_result();
        end
    endtask

    task automatic test_random();
        bit ok; int lat; int elat; int a; int b; int c; int hold; logic [7:0] ed; logic ee;
        for (int i = 0; i < 24; i++) begin
            c = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 4095); b = $urandom_range(0, 4095);
            end else begin
                a = $urandom_range(700, 3995); b = a - (int'($urandom_range(0, 800)) - 100);
            end
            model(a, b, ed, ee, elat);
            send(c, a, b, ok);
            wait_result(lat, ok);
            n_checks++; if (!ok || lat != elat) begin n_fail++; $display("FAIL random%0d_latency got=%0d exp=%0d", i, lat, elat); end
            n_checks++; if (depth !== ed || err !== ee || ch !== 1'(c)) begin
                n_fail++; $display("FAIL random%0d_result x1=%0d x2=%0d got depth=%0d err=%b ch=%0d exp=%0d/%b/%0d", i, a, b, depth, err, ch, ed, ee, c); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                n_checks++; if (depth_valid !== 1'b1 || depth !== ed) begin
                    n_fail++; $display("FAIL random%0d_hold got valid=%b depth=%0d exp=1/%0d", i, depth_valid, depth, ed); end
            end
            release_result();
        end
    endtask

    task automatic test_arbitration();
        int exp_ch; int got; logic [7:0] ed; logic ee; int elat; int dv[2];
        rst_n = 1'b0;
        set_x(0, 600, 595); set_x(1, 1000, 990);
        dv[0] = 600 - 595; dv[1] = 1000 - 990;
        req_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ch = 0; got = 0;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            #1;
            n_checks++; if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL arb_onehot got=%b exp=at most one bit", req_ready); end
            if (depth_valid) begin
                model(dv[exp_ch], 0, ed, ee, elat);
                n_checks++; if (ch !== 1'(exp_ch) || depth !== ed) begin
                    n_fail++; $display("FAIL arb_order%0d got ch=%0d depth=%0d exp=%0d/%0d", got, ch, depth, exp_ch, ed); end
                exp_ch = 1 - exp_ch;
                got++;
                depth_ready = 1'b1;
            end else begin
                depth_ready = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        depth_ready = 1'b0;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL arb_count got=%0d exp=4", got); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [7:0] cap;
        send(1, 900, 890, ok);
        wait_result(lat, ok);
        cap = depth;
        n_checks++; if (!ok || cap !== 8'd49 || ch !== 1'b1) begin n_fail++; $display("FAIL bp_result got depth=%0d ch=%0d exp=49/1", cap, ch); end
        set_x(0, 620, 615);
        req_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (depth_valid !== 1'b1 || depth !== cap || ch !== 1'b1 || err !== 1'b0) begin
                n_fail++; $display("FAIL bp_stable%0d got valid=%b depth=%0d ch=%0d err=%b exp=1/%0d/1/0", i, depth_valid, depth, ch, err, cap); end
            n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_no_accept%0d got=%b exp=00", i, req_ready); end
        end
        release_result();
        #1;
        n_checks++; if (depth_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", depth_valid); end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_idle_ready got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        n_checks++; if (depth_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pending_accept got valid=%b exp=0", depth_valid); end
        wait_result(lat, ok);
        n_checks++; if (!ok || lat != LAT_OK || depth !== 8'd99 || ch !== 1'b0) begin
            n_fail++; $display("FAIL bp_waiting_req got lat=%0d depth=%0d ch=%0d exp=%0d/99/0", lat, depth, ch, LAT_OK); end
        release_result();
    endtask

    task automatic test_async_reset();
        bit ok; int lat;
        send(1, 800, 797, ok);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (depth_valid !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL areset_ctrl got valid=%b ready=%b exp=0/00", depth_valid, req_ready); end
        n_checks++; if ({depth, ch, err} !== 10'd0) begin
            n_fail++; $display("FAIL areset_data got depth=%0d ch=%0d err=%b exp=0/0/0", depth, ch, err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT_OK + 2) @(negedge clk);
        n_checks++; if (depth_valid !== 1'b0) begin n_fail++; $display("FAIL areset_discard got valid=%b exp=0", depth_valid); end
        send(0, 700, 698, ok);
        wait_result(lat, ok);
        n_checks++; if (!ok || lat != LAT_OK || depth !== 8'd247 || err !== 1'b0 || ch !== 1'b0) begin
            n_fail++; $display("FAIL areset_next got lat=%0d depth=%0d err=%b ch=%0d exp=%0d/247/0/0", lat, depth, err, ch, LAT_OK); end
        release_result();
    endtask

    initial begin
        req_valid = '0; depth_ready = 1'b0; x1 = '0; x2 = '0; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_boundary();
        test_random();
        test_arbitration();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=no completion exp=finish within 500000 time units");
        $fatal(1, "watchdog");
    end

endmodule
